dac_spi_tx: RTL



---
 rtl/dac_spi_tx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serial transmitter for a DAC121S101-class converter.
// Sends one 16-bit frame {2'b00, pd[1:0], data_In[11:0]}, MSB first.
// DIN is updated on SCLK rising edges and sampled by the DAC on falling edges.
// CS (SYNC) is active low. A one-cycle tx_done_tick marks the end of a frame.
// Optional build macro DAC_PD_MODE_EN adds the pd_mode input, which sets frame bits 13:12.
// Without the macro, those bits are fixed at 00 (normal operation).
module dac_spi_tx #(
    parameter int CLK_DIV = 4,
    parameter int FRAME_W = 16,
    parameter int DATA_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] data_In,
`ifdef DAC_PD_MODE_EN
    input  logic [1:0]        pd_mode,
`endif
    output logic              SCLK,
    output logic              CS,
    output logic              DIN,
    output logic              busy,
    output logic              tx_done_tick
);

    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t             state, state_nx;
    logic [DIV_W-1:0]   div, div_nx;
    logic [3:0]         bit_cnt, bit_nx;
    logic [FRAME_W-1:0] shreg, shreg_nx;
    logic               sclk_nx, cs_nx, din_nx, busy_nx, tick_nx;
    logic [1:0]         pd;
    logic [FRAME_W-1:0] frame_in;

`ifdef DAC_PD_MODE_EN
    assign pd = pd_mode;
`else
    assign pd = 2'b00;
`endif

    // Control bits 15:14 are always zero; the sample is right-justified.
    assign frame_in = {{(FRAME_W - DATA_W - 2){1'b0}}, pd, data_In};

    // State, counters and all outputs are registered; the shift register holds data only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            div          <= '0;
            bit_cnt      <= '0;
            SCLK         <= 1'b1;
            CS           <= 1'b1;
            DIN          <= 1'b0;
            busy         <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_nx;
            div          <= div_nx;
            bit_cnt      <= bit_nx;
            SCLK         <= sclk_nx;
            CS           <= cs_nx;
            DIN          <= din_nx;
            busy         <= busy_nx;
            tx_done_tick <= tick_nx;
        end
        shreg <= shreg_nx;
    end

    // Next-state and next-output logic for the Idle/Shift/Gap sequence.
    always_comb begin
        state_nx = state;
        div_nx   = div;
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        sclk_nx  = SCLK;
        cs_nx    = CS;
        din_nx   = DIN;
        busy_nx  = busy;
        tick_nx  = 1'b0;
        case (state)
            IDLE: begin
                sclk_nx = 1'b1;
                cs_nx   = 1'b1;
                din_nx  = 1'b0;
                busy_nx = 1'b0;
                if (tx_start) begin
                    shreg_nx = frame_in;
                    bit_nx   = '0;
                    div_nx   = '0;
                    cs_nx    = 1'b0;
                    din_nx   = frame_in[FRAME_W-1];
                    busy_nx  = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (div == DIV_LAST) begin
                    div_nx = '0;
                    if (SCLK) begin
                        // Falling edge: the DAC samples DIN, which holds still.
                        sclk_nx = 1'b0;
                    end else if (bit_cnt == BIT_LAST) begin
                        // Rising edge after the last bit closes the frame.
                        sclk_nx  = 1'b1;
                        cs_nx    = 1'b1;
                        din_nx   = 1'b0;
                        state_nx = GAP;
                        // With a one-cycle gap the tick must land on the first Gap cycle.
                        tick_nx  = (DIV_LAST == '0);
                    end else begin
                        sclk_nx  = 1'b1;
                        shreg_nx = shreg << 1;
                        din_nx   = shreg[FRAME_W-2];
                        bit_nx   = bit_cnt + 4'd1;
                    end
                end else begin
                    div_nx = div + DIV_W'(1);
                end
            end
            GAP: begin
                if (div == DIV_LAST) begin
                    div_nx   = '0;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end else begin
                    div_nx  = div + DIV_W'(1);
                    tick_nx = (div_nx == DIV_LAST);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
